// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_if
//  Description : Data-memory request/ready bus between the LSU and memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
//  Module      : lsu
//  Description : Load/store unit: one memory access per instruction with lane
//                steering, load extension, pipeline stall and fault reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu #(
    parameter int TIMEOUT = 255
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        valid,
    input  wire logic        memread,
    input  wire logic        memwrite,
    input  wire logic [2:0]  funct3,
    input  wire logic [31:0] aluresult,
    input  wire logic [31:0] writedata,
    output logic      [31:0] readdata,
    output logic             done,
    output logic             stall,
    output logic             fault,
    lsu_if.master            mem
);

    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            start, legal, aligned;
    logic [3:0]      be_req;
    logic [31:0]     wdata_req;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     load_ext;

    // Request decode from the live EX/MEM inputs.
    always_comb begin
        start     = valid & (memread | memwrite);
        legal     = 1'b0;
        aligned   = 1'b1;
        be_req    = 4'b1111;
        wdata_req = writedata;
        if (memread ^ memwrite) begin
            if (memread)
                legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            else
                legal = funct3 inside {3'b000, 3'b001, 3'b010};
        end
        case (funct3[1:0])
            2'b00: begin
                be_req    = 4'b0001 << aluresult[1:0];
                wdata_req = {4{writedata[7:0]}};
            end
            2'b01: begin
                aligned   = ~aluresult[0];
                be_req    = aluresult[1] ? 4'b1100 : 4'b0011;
                wdata_req = {2{writedata[15:0]}};
            end
            default: begin
                aligned   = (aluresult[1:0] == 2'b00);
                be_req    = 4'b1111;
                wdata_req = writedata;
            end
        endcase
    end

    always_comb begin
        ld_byte = mem.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = mem.mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_ext = {24'd0, ld_byte};
            3'b101:  load_ext = {16'd0, ld_half};
            default: load_ext = mem.mem_rdata;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        funct3_d      = funct3_q;
        we_d          = we_q;
        be_d          = be_q;
        cnt_d         = cnt_q;
        done          = 1'b0;
        stall         = 1'b0;
        fault         = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = 32'd0;
        mem.mem_wdata = 32'd0;
        mem.mem_be    = 4'd0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (legal && aligned) begin
                        stall    = 1'b1;
                        addr_d   = aluresult;
                        wdata_d  = wdata_req;
                        funct3_d = funct3;
                        we_d     = memwrite;
                        be_d     = be_req;
                        cnt_d    = '0;
                        state_d  = S_BUSY;
                    end else begin
                        fault = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                stall         = 1'b1;
                mem.mem_req   = 1'b1;
                mem.mem_we    = we_q;
                mem.mem_addr  = {addr_q[31:2], 2'b00};
                mem.mem_wdata = wdata_q;
                mem.mem_be    = be_q;
                if (mem.mem_ready) begin
                    rdata_d = we_q ? 32'd0 : load_ext;
                    state_d = S_DONE;
                end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            // valid still shows the same instruction here, so it must not restart.
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                fault   = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            funct3_q <= 3'd0;
            we_q     <= 1'b0;
            be_q     <= 4'd0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            be_q     <= be_d;
            cnt_q    <= cnt_d;
        end
    end

    assign readdata = rdata_q;

endmodule
`default_nettype wire

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit directly downstream of the execute-stage ALU.
- Consumes the ALU result as the effective address and rs2 as store data.
- Performs one data-memory transaction per instruction over a req/ready handshake, with byte-lane steering and sign/zero extension.
- Stalls the pipeline while the transaction is in flight and reports misaligned, illegal or timed-out accesses.

Parameters:
TIMEOUT, 255, max BUSY cycles waiting for mem_ready before abort; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
valid  in  1  EX/MEM instruction valid
memread  in  1  instruction is a load
memwrite  in  1  instruction is a store
funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
aluresult  in  32  effective byte address from ALU
writedata  in  32  rs2 store data
readdata  out  32  extended load result, valid while done=1
done  out  1  one-cycle pulse: access complete
stall  out  1  hold pipeline
fault  out  1  one-cycle pulse: misaligned/illegal/timeout, no completion
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  32  word address {addr[31:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_be  out  4  byte enables
mem_ready  in  1  memory accepts/completes request this cycle
mem_rdata  in  32  read word, valid when mem_ready=1

Behaviour:
- Reset (async, any state): state=IDLE; all outputs and capture/timeout registers 0.
- start = valid & (memread | memwrite), evaluated in IDLE only.
- legal: exactly one of memread/memwrite set.
  - Load funct3 must be in {000,001,010,100,101}.
  - Store funct3 must be in {000,001,010}.
- aligned: h/hu requires addr[0]=0; w requires addr[1:0]=0.
- IDLE:
  - start & legal & aligned: stall=1 combinationally; capture addr, funct3, we, lanes and data; go to BUSY next edge.
  - start & ~(legal & aligned): fault=1 for that cycle (combinational), stall=0, stay IDLE, no mem_req.
- BUSY:
  - mem_req=1, stall=1.
  - mem_we, mem_addr, mem_wdata and mem_be come from captured registers and are stable until mem_ready.
  - Timeout counter increments each BUSY cycle.
  - mem_ready=1: register extended load data (stores: readdata=0); go to DONE.
  - Counter reaches TIMEOUT without mem_ready (TIMEOUT>0): drop mem_req; go to FAULT.
- DONE:
  - done=1, stall=0, readdata valid; next state IDLE.
  - valid is ignored: it is the same instruction leaving the stage and must not reissue.
- FAULT: fault=1, stall=0; next state IDLE; valid ignored.
- Lane rules (k = addr[1:0]):
  - b: be = 1<<k; wdata = {4{wd[7:0]}}.
  - h: be = k[1] ? 1100 : 0011; wdata = {2{wd[15:0]}}.
  - w: be = 1111; wdata = wd.
  - mem_be is also driven on loads.
- Load extract:
  - byte = mem_rdata[8k+7:8k]; half = mem_rdata[16k[1]+15:16k[1]].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- Outside BUSY: mem_req=0 and mem_* outputs are 0.
- Minimum latency: request cycle, ≥1 BUSY cycle, then DONE. With mem_ready in the first BUSY cycle, done asserts 2 edges after start.

Test Plan:
1. sw addr 0x100, wd 0xDEADBEEF, mem_ready on 1st BUSY cycle -> mem_req=1, mem_we=1, addr 0x100, be 1111, wdata 0xDEADBEEF; stall 2 cycles; done pulse.
2. lb addr 0x203, mem_rdata 0x80FF_1234 -> be 1000, readdata 0xFFFFFF80; lbu same -> 0x00000080.
3. sh addr 0x102, wd 0x0000ABCD -> be 1100, wdata 0xABCDABCD; lhu addr 0x102, rdata 0xABCD0000 -> 0x0000ABCD.
4. lw addr 0x101 -> fault=1 that cycle, stall=0, mem_req never rises; store funct3=011 -> fault.
5. lw with mem_ready withheld 3 cycles (TIMEOUT=255) -> mem_* stable and stall=1 throughout, done after ready. TIMEOUT=4, ready never -> mem_req drops after 4 BUSY cycles, fault pulse, back to IDLE.
6. reset asserted mid-BUSY -> mem_req, stall and done go 0 immediately; after release, valid held high in DONE does not reissue the access.
